// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the ALU issue stage.
//   - 4-bit ALUop codes; these must match the ALU's own decoder exactly.
//   - 6-bit MIPS opcode and R-type funct constants.
//   - Immediate-extension mode used by the decoder.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_OR   = 4'd2;
    localparam logic [3:0] ALU_SLLV = 4'd3;
    localparam logic [3:0] ALU_SRAV = 4'd4;
    localparam logic [3:0] ALU_SRLV = 4'd5;
    localparam logic [3:0] ALU_AND  = 4'd6;
    localparam logic [3:0] ALU_ORI  = 4'd7;
    localparam logic [3:0] ALU_XOR  = 4'd8;
    localparam logic [3:0] ALU_NOR  = 4'd9;
    localparam logic [3:0] ALU_SLT  = 4'd10;
    localparam logic [3:0] ALU_SLTU = 4'd11;
    localparam logic [3:0] ALU_SRA  = 4'd12;
    localparam logic [3:0] ALU_SRL  = 4'd13;
    localparam logic [3:0] ALU_SLL  = 4'd14;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [1:0] {
        EXT_SIGN  = 2'd0,
        EXT_ZERO  = 2'd1,
        EXT_UPPER = 2'd2
    } ext_mode_e;

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational MIPS decode into an ALU operand bundle.
//   in : instr[31:0], rs_val/rt_val[WIDTH-1:0] (forwarded GPR values)
//   out: aluop[3:0], op_a/op_b[WIDTH-1:0], s[4:0] (shamt), wreg[4:0], illegal
// Unsupported opcodes/functs yield an all-zero bundle with illegal=1.
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [31:0]      instr,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [3:0]       aluop,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [4:0]       s,
    output logic [4:0]       wreg,
    output logic             illegal
);

    logic [5:0]  opcode, funct;
    logic [4:0]  rt, rd, shamt;
    logic [15:0] imm;
    logic [WIDTH-1:0] imm_sx, imm_zx, imm_up;
    ext_mode_e   ext_mode;
    logic        use_imm;

    assign opcode = instr[31:26];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];

    // Operand values arrive already forwarded, so the rs field itself is not needed.
    logic unused_rs;
    assign unused_rs = ^instr[25:21];

    assign imm_sx = {{(WIDTH-16){imm[15]}}, imm};
    assign imm_zx = {{(WIDTH-16){1'b0}}, imm};
    assign imm_up = imm_zx << 16;

    always_comb begin
        aluop    = ALU_ADD;
        op_a     = rs_val;
        op_b     = rt_val;
        s        = '0;
        wreg     = '0;
        illegal  = 1'b0;
        ext_mode = EXT_SIGN;
        use_imm  = 1'b0;

        case (opcode)
            OP_RTYPE: begin
                wreg = rd;
                case (funct)
                    FN_ADD, FN_ADDU: aluop = ALU_ADD;
                    FN_SUB, FN_SUBU: aluop = ALU_SUB;
                    FN_AND:  aluop = ALU_AND;
                    FN_OR:   aluop = ALU_OR;
                    FN_XOR:  aluop = ALU_XOR;
                    FN_NOR:  aluop = ALU_NOR;
                    FN_SLT:  aluop = ALU_SLT;
                    FN_SLTU: aluop = ALU_SLTU;
                    FN_SLLV: aluop = ALU_SLLV;
                    FN_SRAV: aluop = ALU_SRAV;
                    FN_SRLV: aluop = ALU_SRLV;
                    FN_SLL:  begin aluop = ALU_SLL; s = shamt; end
                    FN_SRL:  begin aluop = ALU_SRL; s = shamt; end
                    FN_SRA:  begin aluop = ALU_SRA; s = shamt; end
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW: begin
                aluop = ALU_ADD;  use_imm = 1'b1; wreg = rt;
            end
            OP_SLTI:  begin aluop = ALU_SLT;  use_imm = 1'b1; wreg = rt; end
            OP_SLTIU: begin aluop = ALU_SLTU; use_imm = 1'b1; wreg = rt; end
            OP_ANDI: begin
                aluop = ALU_AND; use_imm = 1'b1; ext_mode = EXT_ZERO; wreg = rt;
            end
            OP_ORI: begin
                aluop = ALU_ORI; use_imm = 1'b1; ext_mode = EXT_ZERO; wreg = rt;
            end
            OP_XORI: begin
                aluop = ALU_XOR; use_imm = 1'b1; ext_mode = EXT_ZERO; wreg = rt;
            end
            OP_LUI: begin
                // lui rides the adder as 0 + (imm << 16).
                aluop = ALU_ADD; op_a = '0; use_imm = 1'b1; ext_mode = EXT_UPPER; wreg = rt;
            end
            OP_SW:  begin aluop = ALU_ADD; use_imm = 1'b1; end
            OP_BEQ: aluop = ALU_SUB;
            default: illegal = 1'b1;
        endcase

        if (use_imm) begin
            case (ext_mode)
                EXT_SIGN: op_b = imm_sx;
                EXT_ZERO: op_b = imm_zx;
                default:  op_b = imm_up;
            endcase
        end

        if (illegal) begin
            aluop = ALU_ADD;
            op_a  = '0;
            op_b  = '0;
            s     = '0;
            wreg  = '0;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX issue register feeding the ALU.
//   clk, reset (sync, active-low)
//   upstream  : in_valid / in_ready, instr, rs_val, rt_val
//   control   : flush drops both the held and the incoming instruction
//   downstream: out_valid / out_ready, out_A, out_B, out_s, out_aluop,
//               out_wreg, out_illegal
//   issued_cnt: bundles consumed downstream, wraps modulo 2^CNT_W
// Single-entry buffer; a consume and a load on the same edge swap the
// bundle with no bubble.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_A,
    output logic [WIDTH-1:0] out_B,
    output logic [4:0]       out_s,
    output logic [3:0]       out_aluop,
    output logic [4:0]       out_wreg,
    output logic             out_illegal,
    output logic [CNT_W-1:0] issued_cnt
);

    logic [3:0]       dec_aluop;
    logic [WIDTH-1:0] dec_a, dec_b;
    logic [4:0]       dec_s, dec_wreg;
    logic             dec_illegal;

    alu_op_decode #(.WIDTH(WIDTH)) u_dec (
        .instr   (instr),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .aluop   (dec_aluop),
        .op_a    (dec_a),
        .op_b    (dec_b),
        .s       (dec_s),
        .wreg    (dec_wreg),
        .illegal (dec_illegal)
    );

    logic             valid_q, valid_d;
    logic [3:0]       aluop_q, aluop_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [4:0]       s_q, s_d, wreg_q, wreg_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load, consume;

    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready && !flush;
    assign consume  = valid_q && out_ready;

    always_comb begin
        valid_d   = valid_q;
        aluop_d   = aluop_q;
        a_d       = a_q;
        b_d       = b_q;
        s_d       = s_q;
        wreg_d    = wreg_q;
        illegal_d = illegal_q;
        // A flush still counts a bundle that was consumed on that same edge.
        cnt_d     = cnt_q + CNT_W'(consume);

        if (load) begin
            valid_d   = 1'b1;
            aluop_d   = dec_aluop;
            a_d       = dec_a;
            b_d       = dec_b;
            s_d       = dec_s;
            wreg_d    = dec_wreg;
            illegal_d = dec_illegal;
        end else if (consume || flush) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q   <= 1'b0;
            aluop_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            s_q       <= '0;
            wreg_q    <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            aluop_q   <= aluop_d;
            a_q       <= a_d;
            b_q       <= b_d;
            s_q       <= s_d;
            wreg_q    <= wreg_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_aluop   = aluop_q;
    assign out_A       = a_q;
    assign out_B       = b_q;
    assign out_s       = s_q;
    assign out_wreg    = wreg_q;
    assign out_illegal = illegal_q;
    assign issued_cnt  = cnt_q;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX issue register that drives the ALU: decodes a MIPS instruction, selects the ALU operands, and registers `ALUop`, `A`, `B` and `s` for the execute stage.
- It is the producing end of the ALU's operand/opcode interface, so its `ALUop` encoding must match the ALU exactly.
- It is a single-entry pipeline buffer with a valid/ready handshake on both sides, plus a flush input.

Parameters:
- `WIDTH`, 32, datapath width of the operands.
- `CNT_W`, 32, width of the issued-instruction counter.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  upstream holds a decoded-stage instruction.
- `in_ready`  out  1  this stage accepts on the current edge.
- `instr`  in  32  raw MIPS instruction word.
- `rs_val`  in  WIDTH  forwarded GPR[rs].
- `rt_val`  in  WIDTH  forwarded GPR[rt].
- `flush`  in  1  kill the held and incoming instruction (branch/exception).
- `out_valid`  out  1  the registered bundle is valid.
- `out_ready`  in  1  execute stage consumes the bundle.
- `out_A`  out  WIDTH  ALU `A` operand.
- `out_B`  out  WIDTH  ALU `B` operand.
- `out_s`  out  5  ALU `s` input (shamt).
- `out_aluop`  out  4  ALU `ALUop`.
- `out_wreg`  out  5  destination register; 0 = no write.
- `out_illegal`  out  1  opcode/funct not supported.
- `issued_cnt`  out  CNT_W  count of bundles consumed downstream.

Behaviour:
- Reset (`reset`=0 at an edge):
  - All outputs go to 0, including `out_valid` and `issued_cnt`.
  - Reset overrides `flush` and any transfer in the same cycle.
- `in_ready` = !`out_valid` || `out_ready` (combinational).
- Load: on `in_valid` && `in_ready` && !`flush`, register the decoded bundle and set `out_valid`=1. Latency is 1 cycle from acceptance to `out_valid`.
- Consume: on `out_valid` && `out_ready` with no new load, clear `out_valid`. A simultaneous consume and load replaces the bundle with no bubble.
- Flush:
  - `out_valid` becomes 0 at the next edge; the incoming instruction that cycle is dropped.
  - The counter still increments if `out_valid` && `out_ready` were both high that cycle.
- Hold: while `out_valid` && !`out_ready`, every output is stable and `in_ready`=0.
- `issued_cnt` increments on each `out_valid` && `out_ready`; it wraps modulo 2^CNT_W.
- ALUop encoding (fixed): 0 add, 1 sub, 2 or, 3 sllv, 4 srav, 5 srlv, 6 and, 7 ori, 8 xor, 9 nor, 10 slt, 11 sltu, 12 sra, 13 srl, 14 sll. Code 15 is never emitted.
- Decode for R-type (opcode 0), selected by funct; `A`=`rs_val`, `B`=`rt_val`, `wreg`=rd:
  - 0x20/0x21 → 0
  - 0x22/0x23 → 1
  - 0x24 → 6
  - 0x25 → 2
  - 0x26 → 8
  - 0x27 → 9
  - 0x2A → 10
  - 0x2B → 11
  - 0x04 → 3
  - 0x07 → 4
  - 0x06 → 5
  - 0x00 → 14, 0x02 → 13, 0x03 → 12, each with `s`=shamt.
  - For non-shift-immediate functs, `s`=0.
- Decode for I-type; `A`=`rs_val`, `wreg`=rt:
  - addi/addiu (0x08/0x09) → 0, `B`=sign-extended imm.
  - slti 0x0A → 10, `B`=sign-extended imm.
  - sltiu 0x0B → 11, `B`=sign-extended imm.
  - andi 0x0C → 6, `B`=zero-extended imm.
  - ori 0x0D → 7, `B`=zero-extended imm.
  - xori 0x0E → 8, `B`=zero-extended imm.
  - lui 0x0F → 0, `A`=0, `B`=imm<<16.
  - lw 0x23 → 0, `B`=sign-extended imm.
  - sw 0x2B → 0, `B`=sign-extended imm, `wreg`=0.
  - beq 0x04 → 1, `B`=`rt_val`, `wreg`=0.
- Any other opcode or funct: `aluop`=0, `A`=`B`=0, `wreg`=0, `illegal`=1. The bundle still issues normally.
- Instruction 0x00000000 (nop) decodes as sll with `wreg`=0, `illegal`=0.

Decomposition:
- Package `alu_pkg`:
  - 4-bit ALUop constants (the 15 codes above).
  - 6-bit opcode and funct constants.
  - Immediate-extension mode enum: sign / zero / upper.
- One natural combinational sub-module, `alu_op_decode`: `instr`, `rs_val`, `rt_val` → `aluop`, `A`, `B`, `s`, `wreg`, `illegal`. The top-level module holds the register, handshake and counter.

Test Plan:
- Basic issue: `instr`=0x00221821 (addu $3,$1,$2), `rs_val`=5, `rt_val`=7, `out_ready`=1 → next cycle `out_valid`=1, `aluop`=0, `A`=5, `B`=7, `wreg`=3, `illegal`=0; `issued_cnt`=1 after consume.
- Immediate extension:
  - 0x3404F0F0 (ori $4,$0,0xF0F0) → `aluop`=7, `B`=0x0000F0F0, `wreg`=4.
  - 0x2005FFFF (addi) → `aluop`=0, `B`=0xFFFFFFFF.
  - 0x3C011234 (lui) → `A`=0, `B`=0x12340000.
- Shift: 0x00023103 (sra $6,$2,4), `rt_val`=0x80000000 → `aluop`=12, `s`=4, `B`=0x80000000, `wreg`=6.
- Backpressure:
  - Load addu, hold `out_ready`=0 for 3 cycles while presenting ori → `in_ready`=0, outputs unchanged, `issued_cnt` unchanged.
  - Raise `out_ready` → ori loads in the same edge as the consume, with no bubble.
- Flush and illegal:
  - Assert `flush` with `in_valid`=1 while a bundle is held → next cycle `out_valid`=0 and the incoming instruction is lost.
  - `instr`=0xFC000000 → `illegal`=1, `aluop`=0, `wreg`=0.
- Reset: drive `reset`=0 for one edge mid-stream with `out_valid`=1 → all outputs 0, `in_ready`=1 next cycle.
